dc_rrip_victim: RTL and testbench

Replacement stage directly downstream of the data-cache tag check. Consumes each tag-check result (hit/miss, way, set index, tag), maintains per-set 2-bit SRRIP re-reference prediction values (RRPV), promotes the way on a hit, and selects a victim way on a miss. Produces one ack per request carrying the way to use for the data/tag fill, with valid/retry handshakes on both sides.

---
 rtl/dc_rrip_pkg.sv | 35 +++
 rtl/dc_rrip_pick.sv | 28 ++
 rtl/dc_rrip_victim.sv | 112 +++++++++++
 tb/tb_dc_rrip_victim.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_rrip_pkg.sv
// rtl/dc_rrip_pkg.sv - shared types and constants for the SRRIP victim stage
//
// Purpose: geometry, RRPV constants and FSM state type used by dc_rrip_victim
//          and dc_rrip_pick.
// Ports:   none (package).
package dc_rrip_pkg;

  localparam int WAYS      = 4;
  localparam int SETS      = 32;
  localparam int TAG_BITS  = 18;
  localparam int RRPV_BITS = 2;

  // The way field is wider than log2(WAYS) so out-of-range ways can be carried.
  localparam int WAY_W     = 3;
  localparam int WAY_IDX_W = $clog2(WAYS);
  localparam int SET_W     = $clog2(SETS);

  localparam logic [RRPV_BITS-1:0] RMAX = {RRPV_BITS{1'b1}};
  localparam logic [RRPV_BITS-1:0] RINS = RRPV_BITS'(2**RRPV_BITS - 2);
  localparam logic [WAY_W-1:0]     WAYS_LIM = WAY_W'(WAYS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_ACK
  } state_t;

  // All RRPVs of one set, way 0 in the low bits.
  typedef logic [WAYS-1:0][RRPV_BITS-1:0] set_rrpv_t;

  function automatic logic way_legal(input logic [WAY_W-1:0] way);
    return way < WAYS_LIM;
  endfunction

endpackage

// File: rtl/dc_rrip_pick.sv
// rtl/dc_rrip_pick.sv - combinational lowest-index RMAX way finder
//
// Purpose: scan the RRPVs of one set and report the lowest-index way whose
//          RRPV equals RMAX.
// Ports:   rrpv  in  RRPVs of the set being searched
//          found out some way is at RMAX
//          way   out lowest-index way at RMAX (0 when !found)
module dc_rrip_pick
  import dc_rrip_pkg::*;
(
  input  set_rrpv_t        rrpv,
  output logic             found,
  output logic [WAY_W-1:0] way
);

  // Scan from the top down so the lowest matching index is the last writer.
  always_comb begin
    found = 1'b0;
    way   = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (rrpv[i] == RMAX) begin
        found = 1'b1;
        way   = WAY_W'(i);
      end
    end
  end

endmodule

// File: rtl/dc_rrip_victim.sv
// rtl/dc_rrip_victim.sv - SRRIP replacement stage after the data-cache tag check
//
// Purpose: keeps per-set 2-bit RRPVs, promotes hit ways, selects and inserts
//          victims on misses, and returns one ack per request.
// Ports:   clk, reset                       clock, synchronous active-high reset
//          req_valid/req_retry              request handshake (transfer on valid && !retry)
//          req_hit, req_way, req_set, req_tag  tag-check result
//          inv_valid, inv_set, inv_way      single-line RRPV invalidate, always accepted
//          ack_valid/ack_retry              result handshake, held while retried
//          ack_way, ack_set, ack_tag, ack_miss  result fields
module dc_rrip_victim
  import dc_rrip_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_retry,
  input  logic                req_hit,
  input  logic [WAY_W-1:0]    req_way,
  input  logic [SET_W-1:0]    req_set,
  input  logic [TAG_BITS-1:0] req_tag,
  input  logic                inv_valid,
  input  logic [SET_W-1:0]    inv_set,
  input  logic [WAY_W-1:0]    inv_way,
  output logic                ack_valid,
  input  logic                ack_retry,
  output logic [WAY_W-1:0]    ack_way,
  output logic [SET_W-1:0]    ack_set,
  output logic [TAG_BITS-1:0] ack_tag,
  output logic                ack_miss
);

  state_t    state;
  set_rrpv_t rrpv [SETS];

  set_rrpv_t        cur_set;
  logic             pick_found;
  logic [WAY_W-1:0] pick_way;

  // ack_set doubles as the captured set index while searching.
  assign cur_set   = rrpv[ack_set];
  assign req_retry = (state != ST_IDLE);

  dc_rrip_pick u_pick (
    .rrpv  (cur_set),
    .found (pick_found),
    .way   (pick_way)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ack_valid <= 1'b0;
      ack_way   <= '0;
      ack_set   <= '0;
      ack_tag   <= '0;
      ack_miss  <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        rrpv[s] <= {WAYS{RMAX}};
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            ack_set  <= req_set;
            ack_tag  <= req_tag;
            ack_miss <= !req_hit;
            if (req_hit) begin
              ack_way   <= req_way;
              ack_valid <= 1'b1;
              state     <= ST_ACK;
              if (way_legal(req_way)) begin
                rrpv[req_set][req_way[WAY_IDX_W-1:0]] <= '0;
              end
            end else begin
              state <= ST_SEARCH;
            end
          end
        end

        ST_SEARCH: begin
          if (pick_found) begin
            rrpv[ack_set][pick_way[WAY_IDX_W-1:0]] <= RINS;
            ack_way   <= pick_way;
            ack_valid <= 1'b1;
            state     <= ST_ACK;
          end else begin
            // Nothing at RMAX, so no entry can overflow here.
            for (int w = 0; w < WAYS; w++) begin
              rrpv[ack_set][w] <= rrpv[ack_set][w] + RRPV_BITS'(1);
            end
          end
        end

        ST_ACK: begin
          if (!ack_retry) begin
            ack_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase

      // Placed last so it overrides promote, insert and aging on the same entry.
      if (inv_valid && way_legal(inv_way)) begin
        rrpv[inv_set][inv_way[WAY_IDX_W-1:0]] <= RMAX;
      end
    end
  end

endmodule

// File: tb/tb_dc_rrip_victim.sv
// tb/tb_dc_rrip_victim.sv - self-checking bench for dc_rrip_victim
module tb_dc_rrip_victim;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_retry;
  logic        req_hit;
  logic [2:0]  req_way;
  logic [4:0]  req_set;
  logic [17:0] req_tag;
  logic        inv_valid;
  logic [4:0]  inv_set;
  logic [2:0]  inv_way;
  logic        ack_valid;
  logic        ack_retry;
  logic [2:0]  ack_way;
  logic [4:0]  ack_set;
  logic [17:0] ack_tag;
  logic        ack_miss;

  int vectors = 0;
  int miscompares = 0;

  // Reference RRPVs, plain integers.
  int model [32][4];

  // Request presented while an ack is being held off.
  bit          pend_hit;
  logic [2:0]  pend_way;
  logic [4:0]  pend_set;
  logic [17:0] pend_tag;

  always #5 clk = ~clk;

  dc_rrip_victim dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_retry (req_retry),
    .req_hit   (req_hit),
    .req_way   (req_way),
    .req_set   (req_set),
    .req_tag   (req_tag),
    .inv_valid (inv_valid),
    .inv_set   (inv_set),
    .inv_way   (inv_way),
    .ack_valid (ack_valid),
    .ack_retry (ack_retry),
    .ack_way   (ack_way),
    .ack_set   (ack_set),
    .ack_tag   (ack_tag),
    .ack_miss  (ack_miss)
  );

  task automatic model_reset();
    for (int s = 0; s < 32; s++)
      for (int w = 0; w < 4; w++)
        model[s][w] = 3;
  endtask

  // SRRIP miss: age the set until some way reaches 3, take the lowest one.
  task automatic model_miss(input int s, output int victim, output int rounds);
    rounds = 0;
    victim = -1;
    while (victim < 0) begin
      for (int w = 3; w >= 0; w--)
        if (model[s][w] == 3) victim = w;
      if (victim < 0) begin
        for (int w = 0; w < 4; w++) model[s][w] = model[s][w] + 1;
        rounds++;
      end
    end
    model[s][victim] = 2;
  endtask

  task automatic do_req(input bit hit, input logic [2:0] way, input logic [4:0] set,
                        input logic [17:0] tag, input int hold, input bit pend,
                        input string name);
    int lat, exp_lat, victim, rounds;
    logic [2:0] exp_way;
    if (hit) begin
      exp_way = way;
      exp_lat = 1;
      if (way < 4) model[set][way] = 0;
    end else begin
      model_miss(int'(set), victim, rounds);
      exp_way = 3'(victim);
      exp_lat = 2 + rounds;
    end
    vectors++;
    if (req_retry !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle_retry: got %b want 0", name, req_retry);
    end
    req_valid = 1'b1;
    req_hit   = hit;
    req_way   = way;
    req_set   = set;
    req_tag   = tag;
    ack_retry = (hold > 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (ack_valid !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (lat != exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    vectors++;
    if ({ack_way, ack_miss, ack_set, ack_tag} !== {exp_way, !hit, set, tag}) begin
      miscompares++;
      $display("FAIL %s ack_fields: got way=%0d miss=%b set=%0d tag=%h want way=%0d miss=%b set=%0d tag=%h",
               name, ack_way, ack_miss, ack_set, ack_tag, exp_way, !hit, set, tag);
    end
    if (pend && hold > 0) begin
      req_valid = 1'b1;
      req_hit   = pend_hit;
      req_way   = pend_way;
      req_set   = pend_set;
      req_tag   = pend_tag;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      vectors++;
      if ({ack_valid, req_retry, ack_way, ack_miss, ack_set, ack_tag} !==
          {2'b11, exp_way, !hit, set, tag}) begin
        miscompares++;
        $display("FAIL %s hold_stable[%0d]: got valid=%b retry=%b way=%0d set=%0d tag=%h want 1 1 way=%0d set=%0d tag=%h",
                 name, i, ack_valid, req_retry, ack_way, ack_set, ack_tag, exp_way, set, tag);
      end
    end
    ack_retry = 1'b0;
    @(negedge clk);
    vectors++;
    if ({ack_valid, req_retry} !== 2'b00) begin
      miscompares++;
      $display("FAIL %s release: got valid=%b retry=%b want 0 0", name, ack_valid, req_retry);
    end
    for (int w = 0; w < 4; w++) begin
      vectors++;
      if (dut.rrpv[set][w] !== 2'(model[set][w])) begin
        miscompares++;
        $display("FAIL %s rrpv[%0d][%0d]: got %0d want %0d", name, set, w, dut.rrpv[set][w], model[set][w]);
      end
    end
  endtask

  task automatic do_inv(input logic [4:0] set, input logic [2:0] way);
    inv_valid = 1'b1;
    inv_set   = set;
    inv_way   = way;
    @(posedge clk);
    @(negedge clk);
    inv_valid = 1'b0;
    if (way < 4) model[set][way] = 3;
    for (int w = 0; w < 4; w++) begin
      vectors++;
      if (dut.rrpv[set][w] !== 2'(model[set][w])) begin
        miscompares++;
        $display("FAIL inv rrpv[%0d][%0d]: got %0d want %0d", set, w, dut.rrpv[set][w], model[set][w]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b0; req_hit = 1'b0; req_way = '0; req_set = '0; req_tag = '0;
    inv_valid = 1'b0; inv_set = '0; inv_way = '0; ack_retry = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    vectors++;
    if ({ack_valid, ack_way, ack_set, ack_tag, ack_miss, req_retry} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b way=%0d set=%0d tag=%h miss=%b retry=%b want all 0",
               ack_valid, ack_way, ack_set, ack_tag, ack_miss, req_retry);
    end
    for (int s = 0; s < 32; s++)
      for (int w = 0; w < 4; w++) begin
        vectors++;
        if (dut.rrpv[s][w] !== 2'd3) begin
          miscompares++;
          $display("FAIL reset_rrpv[%0d][%0d]: got %0d want 3", s, w, dut.rrpv[s][w]);
        end
      end
  endtask

  task automatic test_first_miss();
    do_req(1'b0, 3'd0, 5'd5, 18'h01234, 0, 1'b0, "first_miss");
    vectors++;
    if (dut.rrpv[5] !== {2'd3, 2'd3, 2'd3, 2'd2}) begin
      miscompares++;
      $display("FAIL first_miss set5: got %h want %h", dut.rrpv[5], 8'hfe);
    end
  endtask

  task automatic test_fill_set();
    for (int i = 0; i < 3; i++)
      do_req(1'b0, 3'd0, 5'd5, 18'(i + 100), 0, 1'b0, "fill_set");
    vectors++;
    if (dut.rrpv[5] !== {2'd2, 2'd2, 2'd2, 2'd2}) begin
      miscompares++;
      $display("FAIL fill_set set5: got %h want %h", dut.rrpv[5], 8'haa);
    end
  endtask

  task automatic test_aging();
    do_req(1'b0, 3'd0, 5'd5, 18'h3abcd, 0, 1'b0, "aging");
    vectors++;
    if (dut.rrpv[5] !== {2'd3, 2'd3, 2'd3, 2'd2}) begin
      miscompares++;
      $display("FAIL aging set5: got %h want %h", dut.rrpv[5], 8'hfe);
    end
  endtask

  task automatic test_hit_then_miss();
    do_req(1'b1, 3'd2, 5'd5, 18'h00222, 0, 1'b0, "hit_way2");
    do_req(1'b0, 3'd0, 5'd5, 18'h00333, 0, 1'b0, "miss_after_hit");
    do_req(1'b1, 3'd5, 5'd7, 18'h00555, 0, 1'b0, "hit_bad_way");
  endtask

  task automatic test_backpressure();
    pend_hit = 1'b1;
    pend_way = 3'd1;
    pend_set = 5'd9;
    pend_tag = 18'h2aaaa;
    do_req(1'b0, 3'd0, 5'd5, 18'h3ffff, 4, 1'b1, "backpressure");
    do_req(pend_hit, pend_way, pend_set, pend_tag, 0, 1'b0, "after_release");
  endtask

  task automatic test_inv_collision();
    int victim, rounds;
    test_reset();
    for (int i = 0; i < 3; i++)
      do_req(1'b0, 3'd0, 5'd5, 18'(i), 0, 1'b0, "coll_fill");
    req_valid = 1'b1; req_hit = 1'b0; req_set = 5'd5; req_tag = 18'h00444;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    inv_valid = 1'b1; inv_set = 5'd5; inv_way = 3'd3;
    @(posedge clk);
    @(negedge clk);
    inv_valid = 1'b0;
    model_miss(5, victim, rounds);
    model[5][3] = 3;
    vectors++;
    if ({ack_valid, ack_way} !== {1'b1, 3'(victim)}) begin
      miscompares++;
      $display("FAIL inv_coll ack: got valid=%b way=%0d want 1 %0d", ack_valid, ack_way, victim);
    end
    vectors++;
    if (dut.rrpv[5][3] !== 2'd3) begin
      miscompares++;
      $display("FAIL inv_coll rrpv[5][3]: got %0d want 3", dut.rrpv[5][3]);
    end
    @(negedge clk);
    // Another miss to set 5, reset while it is searching.
    req_valid = 1'b1; req_hit = 1'b0; req_set = 5'd5; req_tag = 18'h00555;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    vectors++;
    if ({ack_valid, req_retry, ack_tag} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_search: got valid=%b retry=%b tag=%h want 0 0 0", ack_valid, req_retry, ack_tag);
    end
    for (int w = 0; w < 4; w++) begin
      vectors++;
      if (dut.rrpv[5][w] !== 2'd3) begin
        miscompares++;
        $display("FAIL reset_mid_search rrpv[5][%0d]: got %0d want 3", w, dut.rrpv[5][w]);
      end
    end
  endtask

  task automatic test_random();
    int op;
    logic [2:0] way;
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 9);
      if (op < 4) begin
        way = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        do_req(1'b1, way, 5'($urandom_range(0, 3)), 18'($urandom), $urandom_range(0, 2), 1'b0, "rand_hit");
      end else if (op < 8) begin
        do_req(1'b0, 3'd0, 5'($urandom_range(0, 3)), 18'($urandom), $urandom_range(0, 2), 1'b0, "rand_miss");
      end else begin
        do_inv(5'($urandom_range(0, 3)), 3'($urandom_range(0, 4)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_miss();
    test_fill_set();
    test_aging();
    test_hit_then_miss();
    test_backpressure();
    test_inv_collision();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
